// File: rtl/cnn_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_window_gen_pkg
// Description : Shared definitions for the CNN window generator. Holds the
//               default kernel/channel geometry and the single definition
//               of the flattened window index used by cnn_core and by
//               cnn_window_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_window_gen_pkg;

  // Default geometry. The instantiating modules may override these.
  localparam int CI_DEF     = 3;
  localparam int KX_DEF     = 3;
  localparam int KY_DEF     = 3;
  localparam int I_F_BW_DEF = 8;

  // Flattened element position of (ich, ky, kx) inside a window, in units of
  // samples. Multiply by the sample width to get the bit offset.
  function automatic int win_idx(input int ich, input int ky, input int kx,
                                 input int ky_n, input int kx_n);
    return ich * ky_n * kx_n + ky * kx_n + kx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_line_delay.sv
`default_nettype none
// ============================================================================
// Module      : cnn_line_delay
// Description : Enable-gated circular-buffer delay line, DEPTH entries of
//               WIDTH bits. On every enabled cycle the entry at the pointer
//               is presented on dout (the sample written DEPTH enabled
//               cycles earlier) and then overwritten with din.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset (pointer only)
//               en   - advance the delay line by one sample
//               din  - sample entering the line
//               dout - sample leaving the line (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_line_delay
  import cnn_window_gen_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // Read-before-write at the same address: dout reflects the old contents
  // while the write of din lands at the clock edge.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  // Storage carries no reset: stale entries are never emitted downstream.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[ptr] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : cnn_window_gen
// Description : Converts a raster-order pixel stream into flattened
//               KX x KY x CI windows for cnn_core. Buffers KY-1 lines in
//               chained delay lines and keeps a KY x KX register window.
//               One window is emitted, one cycle after the pixel, for every
//               fully interior position (no padding, stride 1).
// Ports       : clk          - rising-edge clock
//               i_soft_reset - synchronous active-high reset
//               i_in_valid   - pixel present this cycle
//               i_in_pixel   - CI samples, channel ich at [ich*I_F_BW +: I_F_BW]
//               o_ot_valid   - one-cycle strobe per window
//               o_ot_fmap    - window, element (ich,ky,kx) at
//                              [(ich*KY*KX + ky*KX + kx)*I_F_BW +: I_F_BW]
//               o_frame_done - pulse with the last window of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int CI     = CI_DEF,
  parameter int KX     = KX_DEF,
  parameter int KY     = KY_DEF,
  parameter int I_F_BW = I_F_BW_DEF,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                         clk,
  input  logic                         i_soft_reset,
  input  logic                         i_in_valid,
  input  logic [CI*I_F_BW-1:0]         i_in_pixel,
  output logic                         o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]   o_ot_fmap,
  output logic                         o_frame_done
);

  localparam int PIX_W  = CI * I_F_BW;
  localparam int FMAP_W = PIX_W * KX * KY;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              accept;
  logic              emit;
  logic              last_pix;

  // chain[0] is the incoming pixel, chain[j+1] is the output of line delay j
  // (the pixel j+1 rows above at the same column).
  logic [PIX_W-1:0]  chain    [KY];
  logic [PIX_W-1:0]  win      [KY][KX];
  logic [PIX_W-1:0]  win_next [KY][KX];
  logic [FMAP_W-1:0] fmap_next;

  // Reset wins over a pixel presented in the same cycle.
  assign accept   = i_in_valid && !i_soft_reset;
  assign emit     = accept && (row >= ROW_W'(KY - 1)) && (col >= COL_W'(KX - 1));
  assign last_pix = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

  assign chain[0] = i_in_pixel;

  generate
    for (genvar j = 0; j < KY - 1; j++) begin : g_line
      cnn_line_delay #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
      ) u_line_delay (
        .clk  (clk),
        .rst  (i_soft_reset),
        .en   (accept),
        .din  (chain[j]),
        .dout (chain[j+1])
      );
    end
  endgenerate

  // Shift the window one column left and load the new rightmost column:
  // bottom row (ky=KY-1) from the incoming pixel, rows above from the
  // progressively deeper line delays.
  always_comb begin
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX - 1; kx++) begin
        win_next[ky][kx] = win[ky][kx+1];
      end
      win_next[ky][KX-1] = chain[KY-1-ky];
    end
  end

  always_comb begin
    fmap_next = '0;
    for (int ich = 0; ich < CI; ich++) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          fmap_next[win_idx(ich, ky, kx, KY, KX)*I_F_BW +: I_F_BW] =
            win_next[ky][kx][ich*I_F_BW +: I_F_BW];
        end
      end
    end
  end

  // Window contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          win[ky][kx] <= win_next[ky][kx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_soft_reset) begin
      col          <= '0;
      row          <= '0;
      o_ot_valid   <= 1'b0;
      o_ot_fmap    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_ot_valid   <= emit;
      o_frame_done <= emit && last_pix;
      // Output register only moves on an emitted window, so it holds across
      // input gaps and across non-interior pixels.
      if (emit) begin
        o_ot_fmap <= fmap_next;
      end
      if (i_in_valid) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          if (row == ROW_W'(IMG_H - 1)) begin
            row <= '0;
          end else begin
            row <= row + ROW_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_window_gen
// Description : Scoreboard bench for cnn_window_gen on a 5x4 image. The
//               driver pushes the expected window for each interior pixel;
//               a monitor pops and compares on every output strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_window_gen;

  localparam int CI = 3, KX = 3, KY = 3, BW = 8, W = 5, H = 4;
  localparam int PW = CI * BW;
  localparam int FW = PW * KX * KY;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic [PW-1:0] pixel;
  logic          o_valid;
  logic [FW-1:0] o_fmap;
  logic          o_done;

  always #5 clk = ~clk;

  cnn_window_gen #(
    .CI(CI), .KX(KX), .KY(KY), .I_F_BW(BW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk          (clk),
    .i_soft_reset (rst),
    .i_in_valid   (vld),
    .i_in_pixel   (pixel),
    .o_ot_valid   (o_valid),
    .o_ot_fmap    (o_fmap),
    .o_frame_done (o_done)
  );

  typedef struct {
    logic [FW-1:0] win;
    bit            done;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [FW-1:0] seen[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  int            strobes    = 0;
  int            dones      = 0;
  bit            hold_chk   = 0;
  logic [FW-1:0] last_exp   = '0;

  function automatic logic [PW-1:0] pix(input int p, input int off);
    logic [PW-1:0] v;
    v = '0;
    for (int ich = 0; ich < CI; ich++) v[ich*BW +: BW] = BW'((p + 64*ich + off) % 256);
    return v;
  endfunction

  // Element (ich,ky,kx) of the window for pixel (r,c) is pixel(r-2+ky, c-2+kx).
  function automatic logic [FW-1:0] model(input int r, input int c, input int off);
    logic [FW-1:0] f;
    int p;
    f = '0;
    for (int ich = 0; ich < CI; ich++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++) begin
          p = (r - KY + 1 + ky) * W + (c - KX + 1 + kx);
          f[(ich*KY*KX + ky*KX + kx)*BW +: BW] = BW'((p + 64*ich + off) % 256);
        end
    return f;
  endfunction

  function automatic int elem(input logic [FW-1:0] f, input int ich, input int ky, input int kx);
    return int'(f[(ich*KY*KX + ky*KX + kx)*BW +: BW]);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) last_exp = '0;
  end

  // Monitor: pops one expected window per strobe; checks hold during gaps.
  always @(negedge clk) begin
    if (o_valid) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe: cycle %0d got strobe expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_fmap !== e.win || o_done !== e.done || cyc != e.cyc) begin
          mismatched++;
          $display("FAIL window: got fmap=%h done=%b cyc=%0d expected fmap=%h done=%b cyc=%0d",
                   o_fmap, o_done, cyc, e.win, e.done, e.cyc);
        end
        last_exp = e.win;
      end
      seen.push_back(o_fmap);
      strobes++;
      if (o_done) dones++;
    end else begin
      if (o_done !== 1'b0) begin
        compared++;
        mismatched++;
        $display("FAIL done_without_valid: got %b expected 0", o_done);
      end
      if (hold_chk) begin
        compared++;
        if (o_fmap !== last_exp) begin
          mismatched++;
          $display("FAIL fmap_hold: got %h expected %h", o_fmap, last_exp);
        end
      end
    end
  end

  task automatic drive_px(input int p, input int off, input bit do_rst);
    int r, c;
    @(posedge clk); #1;
    rst   = do_rst;
    vld   = 1'b1;
    pixel = pix(p, off);
    r = p / W;
    c = p % W;
    if (!do_rst && r >= KY - 1 && c >= KX - 1)
      q.push_back('{win: model(r, c, off), done: (p == W*H - 1), cyc: cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst = 1'b0;
      vld = 1'b0;
    end
  endtask

  task automatic frame(input int off, input bit gaps);
    for (int p = 0; p < W*H; p++) begin
      drive_px(p, off, 1'b0);
      if (gaps) idle(1);
    end
  endtask

  task automatic clear_counts();
    strobes = 0;
    dones   = 0;
    seen.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vld = 1'b0; pixel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", longint'(o_valid), 0);
    check("reset_fmap_zero", longint'(o_fmap != '0), 0);
    check("reset_done", longint'(o_done), 0);
    hold_chk = 1;
    idle(2);

    // Continuous frame
    clear_counts();
    frame(0, 1'b0);
    idle(3);
    check("s1_strobes", strobes, 6);
    check("s1_done_pulses", dones, 1);
    if (seen.size() > 0) begin
      check("s1_e000", elem(seen[0], 0, 0, 0), 0);
      check("s1_e022", elem(seen[0], 0, 2, 2), 12);
      check("s1_e011", elem(seen[0], 0, 1, 1), 6);
      check("s1_e200", elem(seen[0], 2, 0, 0), 128);
      check("s1_e122", elem(seen[0], 1, 2, 2), 76);
    end else check("s1_first_window_present", 0, 1);

    // Same frame with valid toggling
    clear_counts();
    frame(0, 1'b1);
    idle(3);
    check("s2_strobes", strobes, 6);
    check("s2_done_pulses", dones, 1);

    // Two back-to-back frames, second offset by 100
    clear_counts();
    frame(0, 1'b0);
    frame(100, 1'b0);
    idle(3);
    check("s3_strobes", strobes, 12);
    check("s3_done_pulses", dones, 2);
    if (seen.size() > 6) check("s3_f2_e000", elem(seen[6], 0, 0, 0), 100);
    else check("s3_f2_window_present", 0, 1);

    // Reset together with pixel 14, then a fresh frame
    clear_counts();
    for (int p = 0; p < 14; p++) drive_px(p, 0, 1'b0);
    drive_px(14, 0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("s4_post_reset_valid", longint'(o_valid), 0);
    check("s4_post_reset_fmap_zero", longint'(o_fmap != '0), 0);
    check("s4_post_reset_done", longint'(o_done), 0);
    frame(0, 1'b0);
    idle(3);
    check("s4_strobes", strobes, 8);
    check("s4_done_pulses", dones, 1);
    if (seen.size() > 2) check("s4_fresh_e022", elem(seen[2], 0, 2, 2), 12);
    else check("s4_fresh_window_present", 0, 1);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
